desired_drive_seq: RTL and testbench
====================================

# desired_drive_seq

Parametrised, multi-cycle successor to the eBike assist-current calculator. On a `start` pulse it samples rider torque, cadence, incline, assist scale and the pedaling flag, then forms the assist product on a single shared multiplier across three cycles. It saturates the result to the motor-current range and applies an optional per-update slew limit. The output feeds the motor-drive current loop as `target_curr`.

## Interface
- `TORQUE_W`, 12: width of `avg_torque`.
- `TORQUE_MIN`, 12'h380: torque offset subtracted before scaling.
- `INCL_W`, 13: width of signed `incline`.
- `CURR_W`, 12: width of `target_curr`.
- `SHIFT`, 15: right shift applied to the final product.
- `SLEW_STEP`, 0: maximum change of `target_curr` per update. 0 disables slew limiting.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: request a new computation. Sampled only in IDLE.
- `avg_torque` in TORQUE_W: filtered pedal torque, unsigned.
- `cadence` in 5: cadence, unsigned.
- `not_pedaling` in 1: rider not pedaling.
- `incline` in INCL_W: signed incline.
- `scale` in 3: assist level, 0 to 7.
- `target_curr` out CURR_W: registered target motor current.
- `valid` out 1: one-cycle pulse when `target_curr` has just updated.
- `busy` out 1: high while a computation is in flight.

## Operation
- **Factors** are computed combinationally from the inputs and registered on start acceptance.
  - `incline_sat`: `incline` clipped to the signed range [-512, 511].
  - `incline_lim`: `incline_sat` + 256, clipped to [0, 511] (9 bits).
  - `cadence_factor`: `cadence` + 32 if `cadence` > 1, else 0 (6 bits).
  - `torque_pos`: `avg_torque` − `TORQUE_MIN` if the result is positive, else 0 (`TORQUE_W` bits).
  - `np_q`: `not_pedaling` captured at start.
- **FSM** states: IDLE, M1, M2, M3, UPD.
  - IDLE: when `start` is high, capture the factors and go to M1. Otherwise stay in IDLE.
  - M1: `p` ← `torque_pos` × `incline_lim`. Go to M2.
  - M2: `p` ← `p` × `cadence_factor`. Go to M3.
  - M3: `p` ← `p` × `scale`. Go to UPD.
  - UPD: update `target_curr`, pulse `valid`, go to IDLE.
- **Product width** is P_W = `TORQUE_W` + 18 (30 with defaults). All steps are unsigned and no intermediate step is truncated.
- **Saturation**: `raw` = `p` >> `SHIFT`. If `raw` ≥ 2^`CURR_W`, `raw` is forced to all-ones.
- **Update in UPD**:
  - If `np_q` is set, `target_curr` ← 0 immediately, ignoring slew.
  - Else if `SLEW_STEP` = 0, `target_curr` ← `raw`.
  - Else `target_curr` moves toward `raw` by min(`SLEW_STEP`, |`raw` − `target_curr`|), with no overshoot and no wrap.
- `start` while `busy` is ignored and is not queued.

## Timing
- **Reset values**: `target_curr` = 0, `valid` = 0, `busy` = 0, state IDLE, `p` and the factor registers 0.
- **Latency**: `start` sampled at edge E0. `target_curr` updates and `valid` goes high at E4 and stays high for exactly one cycle (E4 to E5).
- `busy` is high from E0 to E4 (states M1 through UPD).
- **Throughput**: a `start` held high through the `valid` cycle is accepted at E5. This gives one result per 5 cycles.
- **Input sampling**: inputs are sampled only at E0. Changes during M1 to UPD have no effect on the result in flight.
- **Reset mid-operation**: `rst` wins over everything. It aborts the computation, `valid` does not pulse, and `target_curr` returns to 0.
- Between updates `target_curr` holds its value.

## Test plan
- **Reset**: assert `rst` for 2 cycles. `target_curr` = 0, `valid` = 0 and `busy` = 0 on the cycle after reset; no `valid` without `start`.
- **Nominal** (defaults): `avg_torque` = 12'h780, `incline` = 0, `cadence` = 16, `scale` = 3, `start` pulse. Exactly 4 edges later `valid` = 1 and `target_curr` = 12'h480; `busy` is high for 4 cycles.
- **Saturation and clipping**: `avg_torque` = 12'hFFF, `incline` = 13'h0FF0, `cadence` = 31, `scale` = 7 → `target_curr` = 12'hFFF. Then `avg_torque` = 12'h300 or `incline` = −300 or `cadence` = 1 (each alone, others nominal) → `target_curr` = 0.
- **Slew** (`SLEW_STEP` = 12'h100): repeat nominal starts from 0. Successive `target_curr` values are 0x100, 0x200, 0x300, 0x400, 0x480, 0x480. Next, a start with `not_pedaling` = 1 gives 0 in one update.
- **Handshake**: pulse `start` again during M2 → ignored, exactly one `valid`. Hold `start` high continuously → `valid` every 5 cycles. Change `avg_torque` during M1 → result reflects the value sampled at E0.
- **Abort**: assert `rst` during M2 with a nonzero computation pending → no `valid`, `target_curr` = 0, `busy` = 0. The next `start` completes normally with nominal values.

Source files
------------

// File: rtl/desired_drive_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : desired_drive_seq_if
//  Brief    : Request/result bundle between the assist planner and the
//             desired_drive_seq current calculator.
//  Revision : 1.0  initial release
// ============================================================================
interface desired_drive_seq_if #(
   parameter int TORQUE_W = 12,
   parameter int INCL_W   = 13,
   parameter int CURR_W   = 12
);
   logic                       start;
   logic [TORQUE_W-1:0]        avg_torque;
   logic [4:0]                 cadence;
   logic                       not_pedaling;
   logic signed [INCL_W-1:0]   incline;
   logic [2:0]                 scale;
   logic [CURR_W-1:0]          target_curr;
   logic                       valid;
   logic                       busy;

   modport master (
      output start, avg_torque, cadence, not_pedaling, incline, scale,
      input  target_curr, valid, busy
   );

   modport slave (
      input  start, avg_torque, cadence, not_pedaling, incline, scale,
      output target_curr, valid, busy
   );
endinterface
`default_nettype wire

// File: rtl/desired_drive_seq.sv
`default_nettype none
// ============================================================================
//  Module   : desired_drive_seq
//  Brief    : Multi-cycle assist-current calculator on one shared multiplier,
//             with saturation and optional per-update slew limiting.
//  Revision : 1.0  initial release
// ============================================================================
module desired_drive_seq #(
   parameter int                  TORQUE_W   = 12,
   parameter logic [TORQUE_W-1:0] TORQUE_MIN = 'h380,
   parameter int                  INCL_W     = 13,
   parameter int                  CURR_W     = 12,
   parameter int                  SHIFT      = 15,
   parameter int                  SLEW_STEP  = 0
) (
   input  wire                    clk,
   input  wire                    rst,
   desired_drive_seq_if.slave     io_drv
);

   localparam int P_W    = TORQUE_W + 18;
   localparam int FACT_W = 9;

   localparam logic signed [INCL_W-1:0] C_INCL_HI = INCL_W'(511);
   localparam logic signed [INCL_W-1:0] C_INCL_LO = INCL_W'(-512);
   localparam logic signed [INCL_W:0]   C_OFS     = (INCL_W+1)'(256);
   localparam logic signed [INCL_W:0]   C_LIM_HI  = (INCL_W+1)'(511);
   localparam logic [CURR_W-1:0]        C_STEP    = CURR_W'(SLEW_STEP);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_M1   = 3'd1,
      S_M2   = 3'd2,
      S_M3   = 3'd3,
      S_UPD  = 3'd4
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic                       w_capture;
   logic                       w_p_load;
   logic                       w_upd;

   logic [TORQUE_W-1:0]        r_torque;
   logic [FACT_W-1:0]          r_incl;
   logic [5:0]                 r_cad;
   logic [2:0]                 r_scale;
   logic                       r_np;
   logic [P_W-1:0]             r_p;
   logic [CURR_W-1:0]          r_curr;
   logic                       r_valid;

   logic signed [INCL_W-1:0]   w_incl_sat;
   logic signed [INCL_W:0]     w_incl_sum;
   logic [FACT_W-1:0]          w_incl_lim;
   logic [5:0]                 w_cad_f;
   logic [TORQUE_W-1:0]        w_torque_pos;

   logic [P_W-1:0]             w_mul_a;
   logic [FACT_W-1:0]          w_mul_b;
   logic [P_W-1:0]             w_prod;

   logic [P_W-1:0]             w_shifted;
   logic                       w_ovf;
   logic [CURR_W-1:0]          w_raw;
   logic                       w_up;
   logic [CURR_W-1:0]          w_diff;
   logic [CURR_W-1:0]          w_slewed;
   logic [CURR_W-1:0]          w_next_curr;

   // Input conditioning, only meaningful at the moment a start is accepted
   always_comb begin
      w_incl_sat = $signed(io_drv.incline);
      if ($signed(io_drv.incline) > C_INCL_HI) begin
         w_incl_sat = C_INCL_HI;
      end else if ($signed(io_drv.incline) < C_INCL_LO) begin
         w_incl_sat = C_INCL_LO;
      end

      w_incl_sum = $signed({w_incl_sat[INCL_W-1], w_incl_sat}) + C_OFS;
      w_incl_lim = w_incl_sum[FACT_W-1:0];
      if (w_incl_sum[INCL_W]) begin
         w_incl_lim = '0;
      end else if (w_incl_sum > C_LIM_HI) begin
         w_incl_lim = '1;
      end

      w_cad_f = (io_drv.cadence > 5'd1) ? ({1'b0, io_drv.cadence} + 6'd32) : 6'd0;

      w_torque_pos = (io_drv.avg_torque > TORQUE_MIN) ?
                     (io_drv.avg_torque - TORQUE_MIN) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_p_load    = 1'b0;
      w_upd       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (io_drv.start) begin
               w_capture   = 1'b1;
               w_state_nxt = S_M1;
            end
         end
         S_M1: begin
            w_p_load    = 1'b1;
            w_state_nxt = S_M2;
         end
         S_M2: begin
            w_p_load    = 1'b1;
            w_state_nxt = S_M3;
         end
         S_M3: begin
            w_p_load    = 1'b1;
            w_state_nxt = S_UPD;
         end
         S_UPD: begin
            w_upd       = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Shared multiplier: the running product accumulates one factor per state.
   // Operands are sized so no step can exceed P_W bits.
   always_comb begin
      w_mul_a = r_p;
      w_mul_b = '0;
      case (r_state)
         S_M1: begin
            w_mul_a = {{(P_W-TORQUE_W){1'b0}}, r_torque};
            w_mul_b = r_incl;
         end
         S_M2:    w_mul_b = {3'b000, r_cad};
         S_M3:    w_mul_b = {6'b000000, r_scale};
         default: w_mul_b = '0;
      endcase
   end

   assign w_prod = w_mul_a * {{(P_W-FACT_W){1'b0}}, w_mul_b};

   assign w_shifted = r_p >> SHIFT;
   assign w_ovf     = |w_shifted[P_W-1:CURR_W];
   assign w_raw     = w_ovf ? {CURR_W{1'b1}} : w_shifted[CURR_W-1:0];

   always_comb begin
      w_up     = (w_raw > r_curr);
      w_diff   = w_up ? (w_raw - r_curr) : (r_curr - w_raw);
      w_slewed = w_raw;
      if (w_diff > C_STEP) begin
         w_slewed = w_up ? (r_curr + C_STEP) : (r_curr - C_STEP);
      end

      w_next_curr = w_slewed;
      if (r_np) begin
         w_next_curr = '0;
      end else if (SLEW_STEP == 0) begin
         w_next_curr = w_raw;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_torque <= '0;
         r_incl   <= '0;
         r_cad    <= '0;
         r_scale  <= '0;
         r_np     <= 1'b0;
         r_p      <= '0;
         r_curr   <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= w_upd;
         if (w_capture) begin
            r_torque <= w_torque_pos;
            r_incl   <= w_incl_lim;
            r_cad    <= w_cad_f;
            r_scale  <= io_drv.scale;
            r_np     <= io_drv.not_pedaling;
         end
         if (w_p_load) begin
            r_p <= w_prod;
         end
         if (w_upd) begin
            r_curr <= w_next_curr;
         end
      end
   end

   assign io_drv.target_curr = r_curr;
   assign io_drv.valid       = r_valid;
   assign io_drv.busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_desired_drive_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_desired_drive_seq
//  Brief    : Scoreboard bench driving a plain and a slew-limited instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_desired_drive_seq;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic               st;
   logic               np;
   logic [11:0]        tq;
   logic [4:0]         cd;
   logic signed [12:0] inc;
   logic [2:0]         sc;

   desired_drive_seq_if #(.TORQUE_W(12), .INCL_W(13), .CURR_W(12)) if0 ();
   desired_drive_seq_if #(.TORQUE_W(12), .INCL_W(13), .CURR_W(12)) if1 ();

   assign if0.start = st;  assign if0.avg_torque = tq; assign if0.cadence = cd;
   assign if0.not_pedaling = np; assign if0.incline = inc; assign if0.scale = sc;
   assign if1.start = st;  assign if1.avg_torque = tq; assign if1.cadence = cd;
   assign if1.not_pedaling = np; assign if1.incline = inc; assign if1.scale = sc;

   desired_drive_seq u_dut0 (.clk(clk), .rst(rst), .io_drv(if0));
   desired_drive_seq #(.SLEW_STEP(256)) u_dut1 (.clk(clk), .rst(rst), .io_drv(if1));

   typedef struct {
      int val;
      int edge_n;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   m_cur[2];
   int   m_disp[2];
   int   m_cnt;
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", tag, cyc, act, exp);
      end
   endtask

   function automatic int calc_raw(int t, int c, int i, int s);
      longint p;
      int tp, il, cf;
      tp = (t > 'h380) ? t - 'h380 : 0;
      il = i;
      if (il > 511)  il = 511;
      if (il < -512) il = -512;
      il = il + 256;
      if (il < 0)    il = 0;
      if (il > 511)  il = 511;
      cf = (c > 1) ? c + 32 : 0;
      p  = longint'(tp) * il * cf * s;
      p  = p >>> 15;
      return (p > 4095) ? 4095 : int'(p);
   endfunction

   function automatic int next_cur(int raw, int cur, int stp, bit n);
      if (n)        return 0;
      if (stp == 0) return raw;
      if (raw > cur) return (raw - cur > stp) ? cur + stp : raw;
      return (cur - raw > stp) ? cur - stp : raw;
   endfunction

   task automatic check_dut(input int d, input logic v, input logic b, input logic [11:0] tc);
      exp_t f;
      bit   has;
      f   = '{0, 0};
      has = 1'b0;
      if (d == 0 && q0.size() != 0) begin has = 1'b1; f = q0[0]; end
      if (d == 1 && q1.size() != 0) begin has = 1'b1; f = q1[0]; end
      chk($sformatf("valid%0d", d), {31'd0, v}, {31'd0, (has && f.edge_n == cyc)});
      if (has && f.edge_n <= cyc) begin
         if (d == 0) void'(q0.pop_front());
         else        void'(q1.pop_front());
         m_disp[d] = f.val;
      end
      chk($sformatf("busy%0d", d), {31'd0, b}, {31'd0, (m_cnt != 0)});
      chk($sformatf("curr%0d", d), {20'd0, tc}, m_disp[d]);
   endtask

   // One clock: predict acceptance from the bench's own view of the sequencer
   task automatic step(input bit s);
      int raw;
      st = s;
      if (rst) begin
         q0.delete();
         q1.delete();
         m_cur  = '{0, 0};
         m_disp = '{0, 0};
         m_cnt  = 0;
      end else if (m_cnt > 0) begin
         m_cnt--;
      end else if (s) begin
         raw      = calc_raw(int'(tq), int'(cd), int'(inc), int'(sc));
         m_cur[0] = next_cur(raw, m_cur[0], 0, np);
         m_cur[1] = next_cur(raw, m_cur[1], 256, np);
         q0.push_back('{m_cur[0], cyc + 5});
         q1.push_back('{m_cur[1], cyc + 5});
         m_cnt = 4;
      end
      @(posedge clk);
      @(negedge clk);
      check_dut(0, if0.valid, if0.busy, if0.target_curr);
      check_dut(1, if1.valid, if1.busy, if1.target_curr);
   endtask

   task automatic nominal();
      tq = 12'h780; inc = 13'sd0; cd = 5'd16; sc = 3'd3; np = 1'b0;
   endtask

   task automatic op();
      step(1'b1);
      repeat (4) step(1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0);
      step(1'b0);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      st  = 1'b0;
      nominal();
      m_cur = '{0, 0}; m_disp = '{0, 0}; m_cnt = 0;
      @(negedge clk);
      do_reset();
      repeat (3) step(1'b0);

      op();                                   // nominal: 0x480 / slewed 0x100

      tq = 12'hFFF; inc = 13'sh0FF0; cd = 5'd31; sc = 3'd7;
      op();                                   // saturates
      nominal(); tq = 12'h300;       op();    // torque below offset
      nominal(); inc = -13'sd300;    op();    // incline clipped to zero
      nominal(); cd = 5'd1;          op();    // cadence too low
      nominal();

      do_reset();
      repeat (6) op();                        // slew ramp
      np = 1'b1; op(); np = 1'b0;

      step(1'b1); step(1'b0); step(1'b1);     // second start lands in M2
      repeat (4) step(1'b0);

      repeat (15) step(1'b1);                 // held start
      repeat (4) step(1'b0);

      step(1'b1);
      tq = 12'hFFF;                           // changed during M1
      repeat (4) step(1'b0);
      nominal();

      step(1'b1); step(1'b0);
      rst = 1'b1; step(1'b0); rst = 1'b0;     // abort in M2
      repeat (5) step(1'b0);
      op();
      repeat (2) step(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
